// File: rtl/seg7_scan_if.sv
// Bundle for the snooped 7-segment display bus and the rebuilt digit values.
// The display side drives segments and selects; the decoder returns values and pulses.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   bad_pattern;
    logic                    update;
    logic                    frame_done;

    modport master (
        output seg_in, dig_sel,
        input  digits, digit_valid, bad_pattern, update, frame_done
    );

    modport slave (
        input  seg_in, dig_sel,
        output digits, digit_valid, bad_pattern, update, frame_done
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus and rebuilds the hex value on each digit
// once the bus has dwelt on that digit long enough to rule out a glitch.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 2);
    localparam logic [CW-1:0] CNT_CAPTURE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    logic [6:0]            seg_norm;
    logic [NUM_DIGITS-1:0] sel_norm;
    logic [6:0]            seg_reg, last_seg_reg;
    logic [NUM_DIGITS-1:0] sel_reg, last_sel_reg;
    logic [CW-1:0]         cnt_reg, cnt_next;
    state_t                state_reg, state_next;
    logic [NUM_DIGITS-1:0] seen_reg, seen_next;
    logic                  update_reg, frame_reg, frame_next;
    logic                  usable, changed, capture;
    logic                  glyph_legal;
    logic [3:0]            glyph_value;

    assign seg_norm = (SEG_ACTIVE_LOW != 0) ? ~bus.seg_in  : bus.seg_in;
    assign sel_norm = (SEL_ACTIVE_LOW != 0) ? ~bus.dig_sel : bus.dig_sel;

    // Sample stage plus a copy of the previously evaluated sample for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg      <= '0;
            sel_reg      <= '0;
            last_seg_reg <= '0;
            last_sel_reg <= '0;
        end else begin
            seg_reg      <= seg_norm;
            sel_reg      <= sel_norm;
            last_seg_reg <= seg_reg;
            last_sel_reg <= sel_reg;
        end
    end

    assign usable  = (sel_reg != '0) && ((sel_reg & (sel_reg - 1'b1)) == '0);
    assign changed = (seg_reg != last_seg_reg) || (sel_reg != last_sel_reg);

    always_comb begin
        glyph_legal = 1'b1;
        glyph_value = 4'h0;
        case (seg_reg)
            7'h3F: glyph_value = 4'h0;
            7'h06: glyph_value = 4'h1;
            7'h5B: glyph_value = 4'h2;
            7'h4F: glyph_value = 4'h3;
            7'h66: glyph_value = 4'h4;
            7'h6D: glyph_value = 4'h5;
            7'h7D: glyph_value = 4'h6;
            7'h07: glyph_value = 4'h7;
            7'h7F: glyph_value = 4'h8;
            7'h6F: glyph_value = 4'h9;
            7'h77: glyph_value = 4'hA;
            7'h7C: glyph_value = 4'hB;
            7'h39: glyph_value = 4'hC;
            7'h5E: glyph_value = 4'hD;
            7'h79: glyph_value = 4'hE;
            7'h71: glyph_value = 4'hF;
            default: glyph_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // cnt_reg is the number of consecutive identical samples seen so far; in HOLD it
    // stays parked at its capture value, so an indefinite hold never wraps.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (!usable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = TRACK;
                    cnt_next   = CNT_ONE;
                end
                TRACK: begin
                    if (changed) begin
                        cnt_next = CNT_ONE;
                    end else if (cnt_reg == CNT_CAPTURE) begin
                        cnt_next   = cnt_reg + CNT_ONE;
                        capture    = 1'b1;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state_next = TRACK;
                        cnt_next   = CNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        seen_next  = seen_reg;
        frame_next = 1'b0;
        if (capture) begin
            seen_next = seen_reg | sel_reg;
            if (&seen_next) begin
                frame_next = 1'b1;
                seen_next  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_reg   <= '0;
            update_reg <= 1'b0;
            frame_reg  <= 1'b0;
        end else begin
            seen_reg   <= seen_next;
            update_reg <= capture;
            frame_reg  <= frame_next;
        end
    end

    assign bus.update     = update_reg;
    assign bus.frame_done = frame_reg;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : gen_digit
            logic [3:0] value_reg;
            logic       valid_reg;
            logic       bad_reg;
            logic       hit;

            assign hit = capture && sel_reg[gi];

            // Blank and illegal patterns keep the last good value on display.
            always_ff @(posedge clk) begin
                if (rst) begin
                    value_reg <= 4'h0;
                    valid_reg <= 1'b0;
                    bad_reg   <= 1'b0;
                end else if (hit) begin
                    if (glyph_legal) begin
                        value_reg <= glyph_value;
                        valid_reg <= 1'b1;
                        bad_reg   <= 1'b0;
                    end else begin
                        valid_reg <= 1'b0;
                        bad_reg   <= (seg_reg != 7'h00);
                    end
                end
            end

            assign bus.digits[4*gi +: 4] = value_reg;
            assign bus.digit_valid[gi]   = valid_reg;
            assign bus.bad_pattern[gi]   = bad_reg;
        end
    endgenerate
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: dwell filtering, decode, blank/bad handling,
// frame completion and reset behaviour, with pulse counters kept by a monitor.
module tb_seg7_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   upd_cnt = 0;
    int   frm_cnt = 0;
    int   orphan_cnt = 0;
    int   base_upd;
    int   base_frm;

    seg7_scan_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS(4), .STABLE_CYCLES(4), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.update === 1'b1)     upd_cnt++;
        if (bus.frame_done === 1'b1) frm_cnt++;
        if (bus.frame_done === 1'b1 && bus.update !== 1'b1) orphan_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic [6:0] seg, input logic [3:0] sel, input int n);
        bus.seg_in  = seg;
        bus.dig_sel = sel;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.seg_in  = 7'($urandom);
        bus.dig_sel = 4'($urandom);
        repeat (2) begin
            @(posedge clk);
            #1;
            bus.seg_in  = 7'($urandom);
            bus.dig_sel = 4'($urandom);
        end
        chk("rst_digits", 32'(bus.digits), 32'h0);
        chk("rst_valid",  32'(bus.digit_valid), 32'h0);
        chk("rst_bad",    32'(bus.bad_pattern), 32'h0);
        chk("rst_update", 32'(bus.update), 32'h0);
        chk("rst_frame",  32'(bus.frame_done), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(7'(i * 13 + 1), 4'(i + 1), 1);
        end
        chk("post_rst_no_update", 32'(upd_cnt), 32'd0);

        // Legal dwell on digit 0, then a long hold.
        drive(7'h00, 4'b0000, 2);
        base_upd = upd_cnt;
        drive(7'h5B, 4'b0001, 5);
        drive(7'h5B, 4'b0001, 2);
        chk("hold5_update", 32'(upd_cnt - base_upd), 32'd1);
        chk("hold5_digit0", 32'(bus.digits[3:0]), 32'h2);
        chk("hold5_valid0", 32'(bus.digit_valid[0]), 32'h1);
        drive(7'h5B, 4'b0001, 20);
        chk("long_hold_single_update", 32'(upd_cnt - base_upd), 32'd1);

        // Four edges is one short of the dwell: never captured.
        base_upd = upd_cnt;
        drive(7'h06, 4'b0010, 4);
        drive(7'h00, 4'b0000, 4);
        chk("hold4_no_update", 32'(upd_cnt - base_upd), 32'd0);
        chk("hold4_valid1",    32'(bus.digit_valid[1]), 32'h0);

        // Glitch of 3 edges followed by a legal dwell.
        base_upd = upd_cnt;
        drive(7'h7D, 4'b0001, 3);
        drive(7'h7C, 4'b0001, 5);
        drive(7'h00, 4'b0000, 3);
        chk("glitch_update", 32'(upd_cnt - base_upd), 32'd1);
        chk("glitch_digit0", 32'(bus.digits[3:0]), 32'hB);

        // Full scan of all four digits completes a frame.
        base_upd = upd_cnt;
        base_frm = frm_cnt;
        drive(7'h3F, 4'b0001, 6);
        drive(7'h06, 4'b0010, 6);
        drive(7'h77, 4'b0100, 6);
        drive(7'h71, 4'b1000, 6);
        drive(7'h00, 4'b0000, 3);
        chk("scan_digits",  32'(bus.digits), 32'hFA10);
        chk("scan_valid",   32'(bus.digit_valid), 32'hF);
        chk("scan_updates", 32'(upd_cnt - base_upd), 32'd4);
        chk("scan_frame",   32'(frm_cnt - base_frm), 32'd1);
        chk("frame_with_update", 32'(orphan_cnt), 32'd0);

        // Bad pattern keeps the value; blank clears both flags.
        drive(7'h6F, 4'b0010, 6);
        drive(7'h01, 4'b0010, 6);
        drive(7'h00, 4'b0000, 3);
        chk("bad_flag1",   32'(bus.bad_pattern[1]), 32'h1);
        chk("bad_valid1",  32'(bus.digit_valid[1]), 32'h0);
        chk("bad_digits",  32'(bus.digits), 32'hFA90);
        drive(7'h00, 4'b0010, 6);
        drive(7'h00, 4'b0000, 3);
        chk("blank_bad1",  32'(bus.bad_pattern[1]), 32'h0);
        chk("blank_valid", 32'(bus.digit_valid), 32'hD);
        chk("blank_digits", 32'(bus.digits), 32'hFA90);

        // Multi-hot and empty selects never capture.
        base_upd = upd_cnt;
        drive(7'h3F, 4'b0011, 10);
        drive(7'h3F, 4'b0000, 10);
        chk("unusable_sel_no_update", 32'(upd_cnt - base_upd), 32'd0);

        // Reset mid-dwell discards the dwell; counting restarts after release.
        base_upd = upd_cnt;
        drive(7'h4F, 4'b0100, 2);
        rst = 1'b1;
        drive(7'h4F, 4'b0100, 1);
        rst = 1'b0;
        chk("midrst_cleared", 32'(bus.digits), 32'h0);
        drive(7'h4F, 4'b0100, 4);
        chk("midrst_no_early_capture", 32'(upd_cnt - base_upd), 32'd0);
        drive(7'h4F, 4'b0100, 6);
        chk("midrst_capture", 32'(upd_cnt - base_upd), 32'd1);
        drive(7'h00, 4'b0000, 3);
        chk("midrst_digits", 32'(bus.digits), 32'h0300);
        chk("midrst_valid",  32'(bus.digit_valid), 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
